univ_shift_reg: RTL and testbench

- Parametrised successor to the team's 8-bit parallel-load register.
- Adds a generic WIDTH, serial in/out, four shift modes, and a multi-step shift engine with a Start/Busy/Done handshake.
- Sits in the lab datapath as the general-purpose register/shifter, driven directly by the bench or by a small controller.

---
 rtl/univ_shift_reg.sv | 137 +++++++++++++
 tb/tb_univ_shift_reg.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parametrised register/shifter with parallel load, serial in/out,
// four shift modes and a multi-step shift engine driven by a Start/Busy/Done handshake.
// Priority at each edge is RST > Load > Start; Load aborts a running operation without Done.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic [1:0]       Mode,
  input  logic             Start,
  input  logic [CNT_W-1:0] Amount,
  input  logic             SIL,
  input  logic             SIR,
  output logic [WIDTH-1:0] A,
  output logic             SOL,
  output logic             SOR,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_ROL  = 2'b11;

  localparam logic [CNT_W-1:0] REM_ONE = CNT_W'(1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [1:0]         mode_q, mode_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   a_step;
  logic               last_step;

  // rem_q is never 0 inside SHIFT; the <= guard just keeps the engine from wrapping if it were
  assign last_step = (rem_q <= REM_ONE);

  // One shift step of the current contents using the mode latched at Start
  always_comb begin
    a_step = a_q;
    case (mode_q)
      MODE_SHL:  a_step = {a_q[WIDTH-2:0], SIR};
      MODE_SHR:  a_step = {SIL, a_q[WIDTH-1:1]};
      MODE_ROL:  a_step = {a_q[WIDTH-2:0], a_q[WIDTH-1]};
      MODE_HOLD: a_step = a_q;
      default:   a_step = a_q;
    endcase
  end

  // State register and all datapath registers; RST wins over everything
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      mode_q  <= MODE_HOLD;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state: Load forces IDLE; Start with a non-zero amount enters SHIFT
  always_comb begin
    state_d = state_q;
    if (Load) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (Start && (Amount != '0)) state_d = S_SHIFT;
        S_SHIFT: if (last_step) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and handshake next values; Busy/Done are registered from these
  always_comb begin
    a_d    = a_q;
    mode_d = mode_q;
    rem_d  = rem_q;
    busy_d = 1'b0;
    done_d = 1'b0;
    if (Load) begin
      // Silent abort: no Done pulse for an interrupted operation
      a_d   = D;
      rem_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            mode_d = Mode;
            rem_d  = Amount;
            busy_d = (Amount != '0);
            // A zero-step command completes immediately
            done_d = (Amount == '0);
          end
        end
        S_SHIFT: begin
          a_d    = a_step;
          rem_d  = rem_q - REM_ONE;
          busy_d = !last_step;
          done_d = last_step;
        end
        default: begin
          busy_d = 1'b0;
          done_d = 1'b0;
        end
      endcase
    end
  end

  // Outputs: serial outs expose the bits about to be shifted out
  assign A    = a_q;
  assign SOL  = a_q[WIDTH-1];
  assign SOR  = a_q[0];
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Testbench for univ_shift_reg (WIDTH=8, CNT_W=4): table of per-edge vectors plus
// hand-written multi-cycle sequences; expectations queued when driven, checked after the edge.
module tb_univ_shift_reg;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       Load = 1'b0;
  logic [7:0] D = '0;
  logic [1:0] Mode = '0;
  logic       Start = 1'b0;
  logic [3:0] Amount = '0;
  logic       SIL = 1'b0;
  logic       SIR = 1'b0;
  logic [7:0] A;
  logic       SOL, SOR, Busy, Done;

  int errors = 0;
  int checks = 0;

  univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST), .Load(Load), .D(D), .Mode(Mode), .Start(Start),
    .Amount(Amount), .SIL(SIL), .SIR(SIR), .A(A), .SOL(SOL), .SOR(SOR),
    .Busy(Busy), .Done(Done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic       load;
    logic [7:0] d;
    logic       start;
    logic [1:0] mode;
    logic [3:0] amt;
    logic       sil;
    logic       sir;
    logic [7:0] exp_a;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  typedef struct {
    logic [7:0] a;
    logic       busy;
    logic       done;
    int         tag;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];

  task automatic add(input logic rst, input logic load, input logic [7:0] d,
                     input logic start, input logic [1:0] mode, input logic [3:0] amt,
                     input logic sil, input logic sir,
                     input logic [7:0] ea, input logic eb, input logic ed);
    vec_t v;
    v.rst = rst; v.load = load; v.d = d; v.start = start; v.mode = mode;
    v.amt = amt; v.sil = sil; v.sir = sir;
    v.exp_a = ea; v.exp_busy = eb; v.exp_done = ed;
    vt.push_back(v);
  endtask

  task automatic chk1(input string name, input int tag, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%02h, expected 0x%02h", name, tag, act, req);
    end
  endtask

  // Drive one edge's inputs, queue its expectation, then check after the edge
  task automatic step(input vec_t v, input int tag);
    exp_t e;
    RST = v.rst; Load = v.load; D = v.d; Start = v.start; Mode = v.mode;
    Amount = v.amt; SIL = v.sil; SIR = v.sir;
    e.a = v.exp_a; e.busy = v.exp_busy; e.done = v.exp_done; e.tag = tag;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard step %0d: queue empty", tag);
    end else begin
      e = sb.pop_front();
      chk1("A",    e.tag, A,            e.a);
      chk1("SOL",  e.tag, {7'd0, SOL},  {7'd0, e.a[7]});
      chk1("SOR",  e.tag, {7'd0, SOR},  {7'd0, e.a[0]});
      chk1("Busy", e.tag, {7'd0, Busy}, {7'd0, e.busy});
      chk1("Done", e.tag, {7'd0, Done}, {7'd0, e.done});
    end
  endtask

  task automatic idle(input logic [7:0] ea, input logic eb, input logic ed, input int tag);
    vec_t v;
    v.rst = 0; v.load = 0; v.d = 8'h00; v.start = 0; v.mode = 2'b00; v.amt = 4'd0;
    v.sil = 0; v.sir = 0; v.exp_a = ea; v.exp_busy = eb; v.exp_done = ed;
    step(v, tag);
  endtask

  initial begin
    logic [7:0] e;
    vec_t v;

    // 1: reset and load
    add(1,0,8'h00,0,2'b00,4'd0,0,0, 8'h00,0,0);
    add(1,0,8'h00,0,2'b00,4'd0,0,0, 8'h00,0,0);
    add(0,1,8'hA5,0,2'b00,4'd0,0,0, 8'hA5,0,0);
    // 2: shift left by 3, SIR=0
    add(0,0,8'h00,1,2'b01,4'd3,0,0, 8'hA5,1,0);
    add(0,0,8'h00,0,2'b00,4'd0,0,0, 8'h4A,1,0);
    add(0,0,8'h00,0,2'b00,4'd0,0,0, 8'h94,1,0);
    add(0,0,8'h00,0,2'b00,4'd0,0,0, 8'h28,0,1);
    add(0,0,8'h00,0,2'b00,4'd0,0,0, 8'h28,0,0);
    // 3: rotate left by 4, then shift right by 2 with SIL=1 started in the Done cycle
    add(0,1,8'hA5,0,2'b00,4'd0,0,0, 8'hA5,0,0);
    add(0,0,8'h00,1,2'b11,4'd4,0,0, 8'hA5,1,0);
    add(0,0,8'h00,0,2'b00,4'd0,0,0, 8'h4B,1,0);
    add(0,0,8'h00,0,2'b00,4'd0,0,0, 8'h96,1,0);
    add(0,0,8'h00,0,2'b00,4'd0,0,0, 8'h2D,1,0);
    add(0,0,8'h00,0,2'b00,4'd0,0,0, 8'h5A,0,1);
    add(0,0,8'h00,1,2'b10,4'd2,1,0, 8'h5A,1,0);
    // Start/Mode/Amount changes mid-operation are ignored
    add(0,0,8'h00,1,2'b01,4'd9,1,0, 8'hAD,1,0);
    add(0,0,8'h00,0,2'b00,4'd0,1,0, 8'hD6,0,1);
    add(0,0,8'h00,0,2'b00,4'd0,0,0, 8'hD6,0,0);
    // 4: Load aborts on the second shift edge
    add(0,1,8'h01,0,2'b00,4'd0,0,0, 8'h01,0,0);
    add(0,0,8'h00,1,2'b01,4'd5,0,0, 8'h01,1,0);
    add(0,0,8'h00,0,2'b00,4'd0,0,0, 8'h02,1,0);
    add(0,1,8'h3C,0,2'b00,4'd0,0,0, 8'h3C,0,0);
    add(0,0,8'h00,0,2'b00,4'd0,0,0, 8'h3C,0,0);
    add(0,0,8'h00,0,2'b00,4'd0,0,0, 8'h3C,0,0);
    // 5: zero amount, then hold mode for 6 steps
    add(0,0,8'h00,1,2'b01,4'd0,0,0, 8'h3C,0,1);
    add(0,0,8'h00,0,2'b00,4'd0,0,0, 8'h3C,0,0);
    add(0,0,8'h00,1,2'b00,4'd6,0,0, 8'h3C,1,0);
    for (int i = 0; i < 5; i++) add(0,0,8'h00,0,2'b00,4'd0,0,0, 8'h3C,1,0);
    add(0,0,8'h00,0,2'b00,4'd0,0,0, 8'h3C,0,1);
    add(0,0,8'h00,0,2'b00,4'd0,0,0, 8'h3C,0,0);
    // 6: reset mid-operation (overrides a simultaneous Load)
    add(0,0,8'h00,1,2'b11,4'd5,0,0, 8'h3C,1,0);
    add(0,0,8'h00,0,2'b00,4'd0,0,0, 8'h78,1,0);
    add(1,1,8'hFF,1,2'b01,4'd3,0,0, 8'h00,0,0);
    add(0,0,8'h00,0,2'b00,4'd0,0,0, 8'h00,0,0);
    // back-to-back single-step commands, second started in the Done cycle
    add(0,1,8'h81,0,2'b00,4'd0,0,0, 8'h81,0,0);
    add(0,0,8'h00,1,2'b01,4'd1,0,1, 8'h81,1,0);
    add(0,0,8'h00,0,2'b00,4'd0,0,1, 8'h03,0,1);
    add(0,0,8'h00,1,2'b10,4'd1,0,0, 8'h03,1,0);
    add(0,0,8'h00,0,2'b00,4'd0,0,0, 8'h01,0,1);
    add(0,0,8'h00,0,2'b00,4'd0,0,0, 8'h01,0,0);

    @(posedge CLK);
    #1;
    foreach (vt[i]) step(vt[i], i);

    // Maximum amount: rotate left 15 times with a live-changing SIR that must not leak in
    v.rst = 0; v.load = 1; v.d = 8'h80; v.start = 0; v.mode = 2'b00; v.amt = 4'd0;
    v.sil = 0; v.sir = 0; v.exp_a = 8'h80; v.exp_busy = 0; v.exp_done = 0;
    step(v, 100);
    v.load = 0; v.start = 1; v.mode = 2'b11; v.amt = 4'd15; v.sir = 1;
    v.exp_a = 8'h80; v.exp_busy = 1; v.exp_done = 0;
    step(v, 101);
    e = 8'h80;
    for (int k = 1; k <= 15; k++) begin
      e = {e[6:0], e[7]};
      v.start = 0; v.mode = 2'b01; v.amt = 4'd2; v.sir = k[0];
      v.exp_a = e; v.exp_busy = (k != 15); v.exp_done = (k == 15);
      step(v, 101 + k);
    end
    // 15 rotations of 8 bits is one rotation right
    chk1("rol15", 200, A, 8'h40);

    // Shift right by 3 with SIL toggling each step: SIL is sampled live
    v.load = 1; v.d = 8'hF0; v.start = 0; v.sil = 0;
    v.exp_a = 8'hF0; v.exp_busy = 0; v.exp_done = 0;
    step(v, 300);
    v.load = 0; v.start = 1; v.mode = 2'b10; v.amt = 4'd3; v.sil = 0;
    v.exp_a = 8'hF0; v.exp_busy = 1;
    step(v, 301);
    v.start = 0; v.sil = 1; v.exp_a = 8'hF8; v.exp_busy = 1; step(v, 302);
    v.sil = 0;            v.exp_a = 8'h7C; v.exp_busy = 1; step(v, 303);
    v.sil = 1;            v.exp_a = 8'hBE; v.exp_busy = 0; v.exp_done = 1; step(v, 304);
    idle(8'hBE, 0, 0, 305);

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
